fifo_ctrl_32x8: RTL

- Single-clock FIFO controller that sequences the 32x8 latch-based RAM as a circular buffer.
- Shares the single RAM port between one writer and one reader using a req/ack handshake and round-robin arbitration.
- Owns the write and read pointers, the fill count and the full/empty flags.
- Drives the RAM address, data, write-enable and chip-select, and captures the RAM's tristated read data.

---
 rtl/fifo_ctrl_32x8.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_ctrl_32x8.sv
// Single-port FIFO controller sequencing a 32x8 latch RAM as a circular buffer.
// One writer and one reader share the RAM port through req/ack and round-robin arbitration.
module fifo_ctrl_32x8 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   fill_count,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_write_enable,
    output logic              ram_chip_select,
    input  logic [DATA_W-1:0] ram_output
);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

    localparam logic [ADDR_W:0] DepthCount = (ADDR_W + 1)'(DEPTH);

    state_e            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              last_grant_wr_q;
    logic              wr_elig;
    logic              rd_elig;
    logic              grant_wr;
    logic              grant_rd;

    assign fill_count = count_q;
    assign full       = (count_q == DepthCount);
    assign empty      = (count_q == '0);

    // The ack mask keeps a side from being re-granted in the cycle it sees its ack.
    assign wr_elig  = wr_req && !full && !wr_ack;
    assign rd_elig  = rd_req && !empty && !rd_ack;
    assign grant_wr = wr_elig && (!rd_elig || !last_grant_wr_q);
    assign grant_rd = rd_elig && !grant_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            last_grant_wr_q  <= 1'b0;
            wr_ack           <= 1'b0;
            rd_ack           <= 1'b0;
            rd_data          <= '0;
            ram_address      <= '0;
            ram_data         <= '0;
            ram_write_enable <= 1'b0;
            ram_chip_select  <= 1'b0;
        end else begin
            wr_ack <= 1'b0;
            rd_ack <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_wr) begin
                        ram_address      <= wr_ptr_q;
                        ram_data         <= wr_data;
                        ram_chip_select  <= 1'b1;
                        ram_write_enable <= 1'b1;
                        last_grant_wr_q  <= 1'b1;
                        state_q          <= StWr;
                    end else if (grant_rd) begin
                        ram_address      <= rd_ptr_q;
                        ram_chip_select  <= 1'b1;
                        ram_write_enable <= 1'b0;
                        last_grant_wr_q  <= 1'b0;
                        state_q          <= StRd;
                    end
                end
                StWr: begin
                    ram_chip_select  <= 1'b0;
                    ram_write_enable <= 1'b0;
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                    count_q          <= count_q + 1'b1;
                    wr_ack           <= 1'b1;
                    state_q          <= StIdle;
                end
                StRd: begin
                    ram_chip_select  <= 1'b0;
                    ram_write_enable <= 1'b0;
                    rd_data          <= ram_output;
                    rd_ptr_q         <= rd_ptr_q + 1'b1;
                    count_q          <= count_q - 1'b1;
                    rd_ack           <= 1'b1;
                    state_q          <= StIdle;
                end
                default: begin
                    ram_chip_select  <= 1'b0;
                    ram_write_enable <= 1'b0;
                    state_q          <= StIdle;
                end
            endcase
        end
    end

endmodule
